mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Sits directly downstream of the execute stage; holds the EX/MEM pipeline register and performs data-memory access for loads and stores.
- Drives a single-request data-memory port using a req/ack handshake, stalls the pipeline until the access completes or times out, and aligns, sign-extends and masks byte/half/word data.
- Produces the MEM/WB register contents for write-back and the MEM-stage forwarding value for the execute stage.

Parameters:
- TIMEOUT, 16, maximum number of cycles dmem_req stays high without dmem_ack before the access is aborted (must be ≥1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pipeline_flush  in  1  when high, the instruction currently presented by EX is captured as a bubble.
- ex_result  in  32  ALU result from EX; this is the address for loads and stores.
- ex_store_data  in  32  forwarded rs2 value from EX (op2_selected).
- ex_opcode  in  7  opcode from EX.
- ex_func3  in  3  func3 from EX.
- ex_rd  in  5  destination register from EX.
- ex_wb_reg_file  in  1  register-file write enable from EX.
- mem_stall  out  1  high while this stage is waiting on memory; upstream stages hold.
- data_forward_mem  out  32  ALU result held in the EX/MEM register (forwarding source).
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word-aligned address: {addr[31:2], 2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte write strobes; 0 for loads.
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  32  read word.
- wb_data  out  32  write-back data (aligned load data or ALU result).
- wb_rd  out  5  write-back destination register.
- wb_reg_file  out  1  write-back enable.
- misaligned_exc  out  1  one-cycle pulse when a misaligned access is dropped.
- bus_err  out  1  one-cycle pulse when an access times out.

Behaviour:
- Reset: all EX/MEM and MEM/WB register contents cleared, FSM set to IDLE, timeout counter set to 0. All outputs are 0 in the cycle after rst is sampled high. Reset asserted during an access drops dmem_req on the next cycle; no write-back occurs.
- EX/MEM capture:
  - When mem_stall=0, capture all ex_* inputs each edge.
  - If pipeline_flush=1, the captured valid bit is 0 and the captured wb_reg_file is 0.
  - When mem_stall=1, hold the EX/MEM register. pipeline_flush has no effect on the instruction already held in MEM.
- Classification:
  - Opcode 0000011 = load; opcode 0100011 = store; anything else = non-memory.
  - Misaligned: LH/LHU/SH (func3 x01) with addr[0]=1; LW/SW (func3 010) with addr[1:0]≠0.
- FSM states IDLE and ACCESS:
  - IDLE: if the held instruction is a valid, aligned load or store, assert dmem_req combinationally from the EX/MEM register.
    - If dmem_ack arrives in the same cycle, complete with zero stall.
    - Otherwise go to ACCESS and assert mem_stall.
  - ACCESS: keep dmem_req high and all dmem_* outputs stable, increment the counter each cycle.
    - On dmem_ack: return to IDLE and clear mem_stall in that same cycle.
    - When the counter reaches TIMEOUT-1 with no ack: pulse bus_err, return to IDLE, suppress write-back, release mem_stall.
- Stall equation: mem_stall = dmem_req & ~dmem_ack & ~timeout_hit.
- Store lanes:
  - SB: wstrb = 4'b0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb = 4'b0011<<(addr[1]*2); wdata = half replicated ×2.
  - SW: wstrb = 4'b1111; wdata = data as-is.
  - Stores never write the register file (wb_reg_file forced to 0).
- Load extraction from dmem_rdata shifted right by addr[1:0]*8:
  - LB: sign-extend 8 bits.
  - LBU: zero-extend 8 bits.
  - LH: sign-extend 16 bits.
  - LHU: zero-extend 16 bits.
  - LW: full word.
- Misaligned access: no dmem_req; misaligned_exc pulses for one cycle; wb_reg_file=0 in MEM/WB.
- MEM/WB capture:
  - On a completion cycle (non-memory instruction, ack received, misaligned, or timeout), load the MEM/WB register.
  - While stalled, load a bubble (wb_reg_file=0, wb_rd=0, wb_data=0).
  - Latency: a non-memory instruction reaches wb_* 2 edges after it is presented at the EX outputs; a load with ack on its first request cycle takes the same.
- wb_data: load data for loads, ex_result otherwise.
- wb_reg_file=1 only when the instruction is valid, its ex_wb_reg_file=1, it is not a store, and it is not dropped (misaligned or timeout).
- rd=0 writes pass through unchanged; the register file ignores them.

Test Plan:
- ALU op, ex_result=0x1234, rd=5, wb=1, no flush → 2 edges later wb_data=0x1234, wb_rd=5, wb_reg_file=1; dmem_req stays 0.
- LB at addr 0x103, dmem_rdata=0x80FF_FF00, ack after 3 wait cycles → mem_stall high for 3 cycles, dmem_addr=0x100, then wb_data=0xFFFF_FF80.
- SH at addr 0x202, data 0x0000_ABCD, ack immediate → dmem_we=1, wstrb=4'b1100, wdata=0xABCD_ABCD, mem_stall never rises, wb_reg_file=0.
- LW at addr 0x6 → no dmem_req, misaligned_exc pulses once, wb_reg_file=0.
- Load with no ack, TIMEOUT=16 → dmem_req high 16 cycles, bus_err pulses once, mem_stall drops, no write-back.
- pipeline_flush with a load presented → bubble captured, no dmem_req. rst asserted mid-ACCESS → dmem_req=0 and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: holds the EX/MEM register, runs a req/ack data-memory access with a
// timeout, and produces the MEM/WB register plus the MEM-stage forwarding value.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_flush,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_func3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wb_reg_file,
    output logic        mem_stall,
    output logic [31:0] data_forward_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_file,
    output logic        misaligned_exc,
    output logic        bus_err
);

    // state  | meaning
    // IDLE   | no access outstanding; a request is issued straight from EX/MEM
    // ACCESS | request outstanding, waiting for dmem_ack or the timeout

    localparam logic [6:0]        OP_LOAD  = 7'b0000011;
    localparam logic [6:0]        OP_STORE = 7'b0100011;
    localparam int unsigned       CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic        mem_valid;
    logic [31:0] mem_result;
    logic [31:0] mem_store_data;
    logic [6:0]  mem_opcode;
    logic [2:0]  mem_func3;
    logic [4:0]  mem_rd;
    logic        mem_wb;

    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        access;
    logic        timeout_hit;
    logic [3:0]  store_strb;
    logic [31:0] store_wdata;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_opcode     <= '0;
            mem_func3      <= '0;
            mem_rd         <= '0;
            mem_wb         <= 1'b0;
        end else if (!mem_stall) begin
            mem_valid      <= ~pipeline_flush;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_opcode     <= ex_opcode;
            mem_func3      <= ex_func3;
            mem_rd         <= ex_rd;
            mem_wb         <= ex_wb_reg_file & ~pipeline_flush;
        end
    end

    assign is_load  = mem_valid & (mem_opcode == OP_LOAD);
    assign is_store = mem_valid & (mem_opcode == OP_STORE);

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0; bytes never misalign.
    assign misaligned = ((mem_func3[1:0] == 2'b01) & mem_result[0]) |
                        ((mem_func3 == 3'b010) & (mem_result[1:0] != 2'b00));

    assign access         = (is_load | is_store) & ~misaligned;
    assign misaligned_exc = (is_load | is_store) & misaligned;

    assign dmem_req    = access;
    assign timeout_hit = dmem_req & ~dmem_ack & (cnt_q == CNT_LAST);
    assign mem_stall   = dmem_req & ~dmem_ack & ~timeout_hit;
    assign bus_err     = timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter tallies request cycles without ack, including the first IDLE one.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (mem_stall) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            ACCESS: begin
                if (mem_stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        store_strb  = 4'b1111;
        store_wdata = mem_store_data;
        case (mem_func3[1:0])
            2'b00: begin
                store_strb  = 4'b0001 << mem_result[1:0];
                store_wdata = {4{mem_store_data[7:0]}};
            end
            2'b01: begin
                store_strb  = 4'b0011 << {mem_result[1], 1'b0};
                store_wdata = {2{mem_store_data[15:0]}};
            end
            default: begin
                store_strb  = 4'b1111;
                store_wdata = mem_store_data;
            end
        endcase
    end

    assign dmem_we          = access & is_store;
    assign dmem_addr        = {mem_result[31:2], 2'b00};
    assign dmem_wdata       = store_wdata;
    assign dmem_wstrb       = dmem_we ? store_strb : 4'b0000;
    assign data_forward_mem = mem_result;

    assign rdata_shifted = dmem_rdata >> {mem_result[1:0], 3'b000};

    always_comb begin
        load_data = dmem_rdata;
        case (mem_func3)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_reg_file <= 1'b0;
        end else if (mem_stall) begin
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_reg_file <= 1'b0;
        end else begin
            wb_data     <= (is_load & dmem_req & dmem_ack) ? load_data : mem_result;
            wb_rd       <= mem_rd;
            wb_reg_file <= mem_valid & mem_wb & ~is_store & ~misaligned_exc & ~timeout_hit;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a byte-lane
// reference model of loads, stores, alignment, stalls and timeouts.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT  = 16;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_ALU   = 7'b0110011;
    localparam logic [6:0]  OP_ALUI  = 7'b0010011;

    logic        clk;
    logic        rst;
    logic        pipeline_flush;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic [4:0]  ex_rd;
    logic        ex_wb_reg_file;
    logic        mem_stall;
    logic [31:0] data_forward_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_file;
    logic        misaligned_exc;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipeline_flush   (pipeline_flush),
        .ex_result        (ex_result),
        .ex_store_data    (ex_store_data),
        .ex_opcode        (ex_opcode),
        .ex_func3         (ex_func3),
        .ex_rd            (ex_rd),
        .ex_wb_reg_file   (ex_wb_reg_file),
        .mem_stall        (mem_stall),
        .data_forward_mem (data_forward_mem),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .wb_data          (wb_data),
        .wb_rd            (wb_rd),
        .wb_reg_file      (wb_reg_file),
        .misaligned_exc   (misaligned_exc),
        .bus_err          (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [7:0]         b [4];
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        int a;
        for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
        a = int'(addr[1:0]);
        case (f3)
            3'b000: begin sb = b[a]; return 32'(int'(sb)); end
            3'b001: begin sh = {b[a+1], b[a]}; return 32'(int'(sh)); end
            3'b100: return {24'd0, b[a]};
            3'b101: return {16'd0, b[a+1], b[a]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] s;
        int a, n;
        s = '0;
        a = int'(addr[1:0]);
        n = acc_size(f3);
        for (int i = 0; i < 4; i++) if (i >= a && i < a + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sdata);
        logic [31:0] w;
        int n;
        n = acc_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sdata[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic drive_nop();
        ex_opcode      = OP_ALUI;
        ex_func3       = 3'b000;
        ex_rd          = 5'd0;
        ex_wb_reg_file = 1'b0;
        ex_result      = $urandom;
        ex_store_data  = $urandom;
        pipeline_flush = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {mem_stall, data_forward_mem, dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  dmem_wstrb, wb_data, wb_rd, wb_reg_file, misaligned_exc, bus_err}, '0);
    endtask

    // Called just after a falling edge; returns just after a later falling edge.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [4:0] rd, input logic wb, input logic flush,
                             input int ack_wait, input logic [31:0] rdata);
        bit is_mem, is_st, mis, acc, acked, timed, done, last;
        int k;
        ex_opcode      = op;
        ex_func3       = f3;
        ex_result      = addr;
        ex_store_data  = sdata;
        ex_rd          = rd;
        ex_wb_reg_file = wb;
        pipeline_flush = flush;
        dmem_ack       = 1'b0;
        @(negedge clk);
        drive_nop();
        is_st  = (op == OP_STORE);
        is_mem = !flush && (op == OP_LOAD || is_st);
        mis    = is_mem && ((int'(addr[1:0]) % acc_size(f3)) != 0);
        acc    = is_mem && !mis;
        acked  = 1'b0;
        timed  = 1'b0;
        if (!acc) begin
            #1;
            chk({tag, " fwd"}, data_forward_mem, addr);
            chk({tag, " misaligned_exc"}, misaligned_exc, mis);
            chk({tag, " no req"}, dmem_req, 1'b0);
            chk({tag, " no stall"}, mem_stall, 1'b0);
            chk({tag, " no bus_err"}, bus_err, 1'b0);
        end else begin
            k    = 0;
            done = 1'b0;
            while (!done) begin
                acked          = (k == ack_wait);
                dmem_ack       = acked;
                dmem_rdata     = acked ? rdata : $urandom;
                pipeline_flush = 1'($urandom_range(0, 1));
                #1;
                last = !acked && (k == TIMEOUT - 1);
                if (k == 0) begin
                    chk({tag, " fwd"}, data_forward_mem, addr);
                    chk({tag, " misaligned_exc"}, misaligned_exc, 1'b0);
                end
                chk({tag, " req"}, dmem_req, 1'b1);
                chk({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({tag, " we"}, dmem_we, is_st);
                chk({tag, " wstrb"}, dmem_wstrb, is_st ? ref_strb(f3, addr) : 4'b0000);
                if (is_st) chk({tag, " wdata"}, dmem_wdata, ref_wdata(f3, sdata));
                chk({tag, " stall"}, mem_stall, !acked && !last);
                chk({tag, " bus_err"}, bus_err, last);
                if (acked || last) begin
                    done  = 1'b1;
                    timed = last;
                end else begin
                    @(negedge clk);
                    k++;
                end
            end
        end
        @(negedge clk);
        dmem_ack       = 1'b0;
        pipeline_flush = 1'b0;
        #1;
        chk({tag, " wb_reg_file"}, wb_reg_file, !flush && wb && !is_st && !mis && !timed);
        if (!flush && wb && !is_st && !mis && !timed) chk({tag, " wb_rd"}, wb_rd, rd);
        if (!flush && !is_mem) chk({tag, " wb_data alu"}, wb_data, addr);
        if (acc && !is_st && acked) chk({tag, " wb_data load"}, wb_data, ref_load(f3, addr, rdata));
        chk({tag, " next req"}, dmem_req, 1'b0);
        chk({tag, " exc cleared"}, {misaligned_exc, bus_err}, 2'b00);
    endtask

    task automatic reset_mid_access();
        ex_opcode      = OP_LOAD;
        ex_func3       = 3'b010;
        ex_result      = 32'h0000_0300;
        ex_store_data  = '0;
        ex_rd          = 5'd3;
        ex_wb_reg_file = 1'b1;
        pipeline_flush = 1'b0;
        dmem_ack       = 1'b0;
        @(negedge clk);
        drive_nop();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rstmid req", dmem_req, 1'b1);
            chk("rstmid stall", mem_stall, 1'b1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("rstmid all zero");
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid no wb", wb_reg_file, 1'b0);
        chk("rstmid no req", dmem_req, 1'b0);
    endtask

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  ld_f3 [5];
        logic [6:0]  other_op [4];
        int sel, n, wt;
        ld_f3    = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        other_op = '{OP_ALU, OP_ALUI, 7'b1100011, 7'b0110111};

        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive_nop();
        ex_opcode      = OP_LOAD;
        ex_wb_reg_file = 1'b1;
        ex_rd          = 5'd9;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset all zero");
        rst = 1'b0;
        drive_nop();

        run_instr("alu",       OP_ALU,   3'b000, 32'h0000_1234, 32'h0,          5'd5,  1'b1, 1'b0, 0,  32'h0);
        run_instr("lb wait3",  OP_LOAD,  3'b000, 32'h0000_0103, 32'h0,          5'd7,  1'b1, 1'b0, 3,  32'h80FF_FF00);
        run_instr("sh imm",    OP_STORE, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd4,  1'b1, 1'b0, 0,  32'h0);
        run_instr("lw mis",    OP_LOAD,  3'b010, 32'h0000_0006, 32'h0,          5'd8,  1'b1, 1'b0, 0,  32'h0);
        run_instr("lw tmo",    OP_LOAD,  3'b010, 32'h0000_0040, 32'h0,          5'd10, 1'b1, 1'b0, -1, 32'h0);
        run_instr("lw flush",  OP_LOAD,  3'b010, 32'h0000_0080, 32'h0,          5'd11, 1'b1, 1'b1, 0,  32'h1111_2222);
        run_instr("lhu hi",    OP_LOAD,  3'b101, 32'h0000_0012, 32'h0,          5'd12, 1'b1, 1'b0, 1,  32'h9ABC_1234);
        run_instr("lh hi",     OP_LOAD,  3'b001, 32'h0000_0012, 32'h0,          5'd13, 1'b1, 1'b0, 0,  32'h9ABC_1234);
        run_instr("sb lane3",  OP_STORE, 3'b000, 32'h0000_0017, 32'hDEAD_BE5A, 5'd1,  1'b1, 1'b0, 2,  32'h0);
        run_instr("sh mis",    OP_STORE, 3'b001, 32'h0000_0021, 32'h0000_5555, 5'd0,  1'b0, 1'b0, 0,  32'h0);
        run_instr("alu rd0",   OP_ALUI,  3'b000, 32'hCAFE_F00D, 32'h0,          5'd0,  1'b1, 1'b0, 0,  32'h0);
        reset_mid_access();

        for (int t = 0; t < 60; t++) begin
            sel  = $urandom_range(0, 9);
            addr = $urandom;
            if (sel < 4) begin
                op = OP_LOAD;
                f3 = ld_f3[$urandom_range(0, 4)];
            end else if (sel < 7) begin
                op = OP_STORE;
                f3 = 3'($urandom_range(0, 2));
            end else begin
                op = other_op[$urandom_range(0, 3)];
                f3 = 3'($urandom_range(0, 7));
            end
            n = acc_size(f3);
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
            wt = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            run_instr($sformatf("rnd%0d", t), op, f3, addr, $urandom, 5'($urandom),
                      1'($urandom), ($urandom_range(0, 7) == 0), wt, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
